mem_bus_unit: RTL

- Single-port memory bus unit for the pipelined RISC-V core.
- Arbitrates instruction fetch and load/store traffic onto one memory port, with data priority.
- Generates byte enables, lane-replicates store data, and sign/zero-extends loads.
- Runs a handshaked, multi-cycle memory transaction with an optional wait-state timeout, and drives the pipeline stall.

---
 rtl/mem_bus_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_unit.sv
// rtl/mem_bus_unit.sv - single-port memory bus unit: fetch/data arbitration, lane steering, load extension
// Optional wait-state timeout enabled by defining MEM_BUS_UNIT_TIMEOUT_EN.
module mem_bus_unit #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_valid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              timeout
);
    localparam int NB = XLEN / 8;

    if (XLEN != 32 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_param
        $error("mem_bus_unit: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   mem_adr_nx;
    logic                mem_re_nx, mem_we_nx;
    logic [NB-1:0]       mem_be_nx;
    logic [XLEN-1:0]     mem_wdata_nx;
    logic                if_valid_nx, d_valid_nx, d_err_nx;
    logic [XLEN-1:0]     if_rdata_nx, d_rdata_nx;
    logic [2:0]          f3_q, f3_nx;
    logic [1:0]          lane_q, lane_nx;
    logic [1:0]          d_size;
    logic                d_misaligned;
    logic [XLEN-1:0]     store_rep;
    logic                unused_if_addr_lsbs;

    assign unused_if_addr_lsbs = &{1'b0, if_addr[1:0]};

    // size code: 00 byte, 01 half, anything else is treated as a word
    assign d_size       = d_funct3[1:0];
    assign d_misaligned = (d_size == 2'b01 && d_addr[0]) || (d_size[1] && d_addr[1:0] != 2'b00);

    always_comb begin
        case (d_size)
            2'b00:   store_rep = {NB{d_wdata[7:0]}};
            2'b01:   store_rep = {(NB/2){d_wdata[15:0]}};
            default: store_rep = d_wdata;
        endcase
    end

    function automatic logic [NB-1:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return NB'(1) << lane;
            2'b01:   return NB'(3) << lane;
            default: return '1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b100:  return {{(XLEN-8){1'b0}}, b};
            3'b101:  return {{(XLEN-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

`ifdef MEM_BUS_UNIT_TIMEOUT_EN
    logic [7:0] wait_cnt, cnt_nx;
    logic       timeout_q, timeout_nx;
`endif

    always_comb begin
        state_nx     = state;
        mem_adr_nx   = mem_adr;
        mem_re_nx    = mem_re;
        mem_we_nx    = mem_we;
        mem_be_nx    = mem_be;
        mem_wdata_nx = mem_wdata;
        f3_nx        = f3_q;
        lane_nx      = lane_q;
        if_valid_nx  = 1'b0;
        if_rdata_nx  = '0;
        d_valid_nx   = 1'b0;
        d_rdata_nx   = '0;
        d_err_nx     = 1'b0;
`ifdef MEM_BUS_UNIT_TIMEOUT_EN
        cnt_nx       = wait_cnt;
        timeout_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_BUS_UNIT_TIMEOUT_EN
                cnt_nx = '0;
`endif
                // a port whose valid is high this cycle is still holding its completed req
                if (d_req && !d_valid) begin
                    if (d_misaligned) begin
                        d_valid_nx = 1'b1;
                        d_err_nx   = 1'b1;
                    end else begin
                        mem_adr_nx   = {d_addr[ADDR_W-1:2], 2'b00};
                        mem_re_nx    = !d_we;
                        mem_we_nx    = d_we;
                        mem_be_nx    = lane_be(d_size, d_addr[1:0]);
                        mem_wdata_nx = d_we ? store_rep : '0;
                        f3_nx        = d_funct3;
                        lane_nx      = d_addr[1:0];
                        state_nx     = DATA_WAIT;
                    end
                end else if (if_req && !if_valid) begin
                    mem_adr_nx   = {if_addr[ADDR_W-1:2], 2'b00};
                    mem_re_nx    = 1'b1;
                    mem_we_nx    = 1'b0;
                    mem_be_nx    = '1;
                    mem_wdata_nx = '0;
                    state_nx     = FETCH_WAIT;
                end
            end
            default: begin
                if (mem_ready) begin
                    mem_re_nx = 1'b0;
                    mem_we_nx = 1'b0;
                    state_nx  = IDLE;
                    if (state == FETCH_WAIT) begin
                        if_valid_nx = 1'b1;
                        if_rdata_nx = mem_rdata;
                    end else begin
                        d_valid_nx = 1'b1;
                        d_rdata_nx = mem_we ? '0 : load_ext(f3_q, lane_q, mem_rdata);
                    end
                end
`ifdef MEM_BUS_UNIT_TIMEOUT_EN
                else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    mem_re_nx  = 1'b0;
                    mem_we_nx  = 1'b0;
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                    if (state == FETCH_WAIT) begin
                        if_valid_nx = 1'b1;
                    end else begin
                        d_valid_nx = 1'b1;
                        d_err_nx   = 1'b1;
                    end
                end else begin
                    cnt_nx = wait_cnt + 8'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_adr   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_adr   <= mem_adr_nx;
            mem_re    <= mem_re_nx;
            mem_we    <= mem_we_nx;
            mem_be    <= mem_be_nx;
            mem_wdata <= mem_wdata_nx;
            f3_q      <= f3_nx;
            lane_q    <= lane_nx;
            if_valid  <= if_valid_nx;
            if_rdata  <= if_rdata_nx;
            d_valid   <= d_valid_nx;
            d_rdata   <= d_rdata_nx;
            d_err     <= d_err_nx;
        end
    end

`ifdef MEM_BUS_UNIT_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt  <= cnt_nx;
            timeout_q <= timeout_nx;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // gated by reset so every output reads 0 while reset is held
    assign stall = reset & ((if_req & ~if_valid) | (d_req & ~d_valid));

endmodule
